// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes the byte stream from the UART receiver into
// register-file write/read strobes and ALU requests.
// Frames: 0xAA ADDR DATA (write), 0xBB ADDR (read), 0xCC A B FUN (ALU with
// operands), 0xDD FUN (ALU reusing held operands). A corrupted byte aborts
// the frame in progress and returns the FSM to IDLE.
// Optional feature: define UART_CMD_ERR_CNT_EN to build the saturating
// discarded-frame counter on ERR_CNT; otherwise ERR_CNT is tied to 0.
module uart_cmd_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  parity_error,
    input  logic                  framing_error,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic [DATA_WIDTH-1:0] OP_A,
    output logic [DATA_WIDTH-1:0] OP_B,
    output logic [7:0]            ERR_CNT
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'('hDD);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_OPA, S_ALU_OPB, S_ALU_FUN
    } state_t;

    state_t state, state_nxt;

    logic good_byte, bad_byte;
    logic fire_wr, fire_rd, fire_alu;
    logic load_addr, load_a, load_b, set_ops, clr_ops;

    // Staging registers: frame fields are collected here and only copied to
    // the held outputs when the frame completes, so an aborted frame leaves
    // the outputs untouched.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] opa_q, opb_q;
    logic                  with_ops;

    assign good_byte = RX_D_VLD && !parity_error && !framing_error;
    assign bad_byte  = RX_D_VLD && (parity_error || framing_error);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and per-byte actions.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt = state;
        fire_wr   = 1'b0;
        fire_rd   = 1'b0;
        fire_alu  = 1'b0;
        load_addr = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        set_ops   = 1'b0;
        clr_ops   = 1'b0;
        if (bad_byte) begin
            state_nxt = S_IDLE;
        end else if (good_byte) begin
            unique case (state)
                S_IDLE: begin
                    if (RX_P_DATA == CMD_WR)          state_nxt = S_WR_ADDR;
                    else if (RX_P_DATA == CMD_RD)     state_nxt = S_RD_ADDR;
                    else if (RX_P_DATA == CMD_ALU_OP) begin
                        state_nxt = S_ALU_OPA;
                        set_ops   = 1'b1;
                    end else if (RX_P_DATA == CMD_ALU) begin
                        state_nxt = S_ALU_FUN;
                        clr_ops   = 1'b1;
                    end
                end
                S_WR_ADDR: begin load_addr = 1'b1; state_nxt = S_WR_DATA; end
                S_WR_DATA: begin fire_wr   = 1'b1; state_nxt = S_IDLE;    end
                S_RD_ADDR: begin fire_rd   = 1'b1; state_nxt = S_IDLE;    end
                S_ALU_OPA: begin load_a    = 1'b1; state_nxt = S_ALU_OPB; end
                S_ALU_OPB: begin load_b    = 1'b1; state_nxt = S_ALU_FUN; end
                S_ALU_FUN: begin fire_alu  = 1'b1; state_nxt = S_IDLE;    end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Staging registers, strobes and held outputs.
    always_ff @(posedge CLK) begin
        // NOTE: the staging registers are reset along with the outputs; they
        // are a handful of flops, not a memory, so the reset costs nothing.
        if (!RST) begin
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            ALU_EN     <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_FUN    <= '0;
            OP_A       <= '0;
            OP_B       <= '0;
            addr_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            with_ops   <= 1'b0;
        end else begin
            RF_WrEn <= fire_wr;
            RF_RdEn <= fire_rd;
            ALU_EN  <= fire_alu;
            if (load_addr) addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (load_a)    opa_q  <= RX_P_DATA;
            if (load_b)    opb_q  <= RX_P_DATA;
            if (set_ops)      with_ops <= 1'b1;
            else if (clr_ops) with_ops <= 1'b0;
            if (fire_wr) begin
                RF_Address <= addr_q;
                RF_WrData  <= RX_P_DATA;
            end
            if (fire_rd) RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (fire_alu) begin
                ALU_FUN <= RX_P_DATA[3:0];
                // 0xDD frames reuse whatever operands were last committed.
                if (with_ops) begin
                    OP_A <= opa_q;
                    OP_B <= opb_q;
                end
            end
        end
    end

`ifdef UART_CMD_ERR_CNT_EN
    logic err_evt;
    assign err_evt = bad_byte ||
                     (good_byte && state == S_IDLE &&
                      !(RX_P_DATA inside {CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU}));

    // Saturating count of corrupted bytes and unknown commands.
    always_ff @(posedge CLK) begin
        if (!RST)                          ERR_CNT <= '0;
        else if (err_evt && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 8'd1;
    end
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames with literal
// expectations, then randomized frames, corruption, unknown commands and
// resets, all checked every cycle against a frame-level reference model.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_vld = 1'b0;
    logic       pe = 1'b0;
    logic       fe = 1'b0;

    logic       wr_en, rd_en, alu_en;
    logic [3:0] rf_addr, alu_fun;
    logic [7:0] wr_data, op_a, op_b, err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    uart_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(clk), .RST(rst), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .parity_error(pe), .framing_error(fe),
        .RF_WrEn(wr_en), .RF_RdEn(rd_en), .RF_Address(rf_addr),
        .RF_WrData(wr_data), .ALU_EN(alu_en), .ALU_FUN(alu_fun),
        .OP_A(op_a), .OP_B(op_b), .ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model (frame level) ----------------
    bit         e_wr, e_rd, e_alu;
    logic [3:0] e_addr, e_fun;
    logic [7:0] e_wdata, e_opa, e_opb;
    int         e_err;
    bit         err_counting;
    logic [7:0] frame[$];

    initial begin
`ifdef UART_CMD_ERR_CNT_EN
        err_counting = 1'b1;
`else
        err_counting = 1'b0;
`endif
    end

    function automatic void count_err();
        if (err_counting && e_err < 255) e_err++;
    endfunction

    always @(posedge clk) begin
        e_wr = 0; e_rd = 0; e_alu = 0;
        if (!rst) begin
            e_addr = 0; e_fun = 0; e_wdata = 0; e_opa = 0; e_opb = 0; e_err = 0;
            frame.delete();
        end else if (rx_vld) begin
            if (pe || fe) begin
                frame.delete();
                count_err();
            end else begin
                frame.push_back(rx_data);
                case (frame[0])
                    8'hAA: if (frame.size() == 3) begin
                        e_wr = 1; e_addr = frame[1][3:0]; e_wdata = frame[2]; frame.delete();
                    end
                    8'hBB: if (frame.size() == 2) begin
                        e_rd = 1; e_addr = frame[1][3:0]; frame.delete();
                    end
                    8'hCC: if (frame.size() == 4) begin
                        e_alu = 1; e_opa = frame[1]; e_opb = frame[2];
                        e_fun = frame[3][3:0]; frame.delete();
                    end
                    8'hDD: if (frame.size() == 2) begin
                        e_alu = 1; e_fun = frame[1][3:0]; frame.delete();
                    end
                    default: begin
                        frame.delete();
                        count_err();
                    end
                endcase
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        int n_strobes;
        check("RF_WrEn", wr_en, e_wr);
        check("RF_RdEn", rd_en, e_rd);
        check("ALU_EN", alu_en, e_alu);
        check("RF_Address", rf_addr, e_addr);
        check("RF_WrData", wr_data, e_wdata);
        check("ALU_FUN", alu_fun, e_fun);
        check("OP_A", op_a, e_opa);
        check("OP_B", op_b, e_opb);
        check("ERR_CNT", err_cnt, e_err);
        n_strobes = int'(wr_en) + int'(rd_en) + int'(alu_en);
        check("one_strobe", n_strobes <= 1, 1);
    end

    // ---------------- Stimulus helpers ----------------
    task automatic drive(input logic [7:0] b, input bit p = 0, input bit f = 0);
        @(negedge clk);
        rx_data = b; rx_vld = 1'b1; pe = p; fe = f;
    endtask

    // Idle cycles carry junk on the data and flag lines; they must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_vld = 1'b0; rx_data = 8'($urandom); pe = 1'($urandom); fe = 1'($urandom);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0; rx_vld = 1'($urandom); rx_data = 8'($urandom); pe = 1'b0; fe = 1'b0;
        @(negedge clk);
        rst = 1'b1; rx_vld = 1'b0;
    endtask

    function automatic logic [7:0] rand_unknown();
        logic [7:0] b;
        do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
        return b;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] cmds [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int         lens [4] = '{3, 2, 4, 2};

    initial begin
        int exp_err1, exp_err2, exp_sat;
        exp_err1 = err_counting ? 1 : 0;
        exp_err2 = err_counting ? 2 : 0;
        exp_sat  = err_counting ? 255 : 0;

        repeat (3) @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_op_a", op_a, 0);
        check("reset_err_cnt", err_cnt, 0);
        rst = 1'b1;
        idle(2);

        // Write frame.
        drive(8'hAA); drive(8'h05); drive(8'h3C); idle(1);
        check("tp_wr_strobe", wr_en, 1);
        check("tp_wr_addr", rf_addr, 4'h5);
        check("tp_wr_data", wr_data, 8'h3C);
        idle(1);
        check("tp_wr_one_cycle", wr_en, 0);

        // Read frame with truncated address.
        drive(8'hBB); drive(8'h1F); idle(1);
        check("tp_rd_strobe", rd_en, 1);
        check("tp_rd_addr", rf_addr, 4'hF);
        check("tp_rd_no_wr", wr_en, 0);

        // ALU with operands, then back-to-back ALU reusing operands.
        drive(8'hCC); drive(8'h12); drive(8'h34); drive(8'h02);
        drive(8'hDD);
        check("tp_alu_strobe", alu_en, 1);
        check("tp_alu_opa", op_a, 8'h12);
        check("tp_alu_opb", op_b, 8'h34);
        check("tp_alu_fun", alu_fun, 4'h2);
        drive(8'h07); idle(1);
        check("tp_alu2_strobe", alu_en, 1);
        check("tp_alu2_fun", alu_fun, 4'h7);
        check("tp_alu2_opa_held", op_a, 8'h12);
        check("tp_alu2_opb_held", op_b, 8'h34);

        // Corrupted byte aborts a write frame.
        drive(8'hAA); drive(8'h03); drive(8'h99, 1'b1, 1'b0); idle(1);
        check("tp_bad_no_wr", wr_en, 0);
        check("tp_bad_err_cnt", err_cnt, exp_err1);
        check("tp_bad_addr_held", rf_addr, 4'hF);
        drive(8'hBB); drive(8'h03); idle(1);
        check("tp_after_bad_rd", rd_en, 1);
        check("tp_after_bad_addr", rf_addr, 4'h3);

        // Unknown command, then saturation.
        drive(8'h55); idle(1);
        check("tp_unknown_err", err_cnt, exp_err2);
        for (int i = 0; i < 300; i++) drive(8'($urandom), 1'($urandom), 1'b1);
        idle(1);
        check("tp_saturate", err_cnt, exp_sat);

        // Reset mid-frame.
        drive(8'hCC); drive(8'h11);
        pulse_reset();
        check("tp_rst_op_a", op_a, 0);
        check("tp_rst_addr", rf_addr, 0);
        check("tp_rst_err_cnt", err_cnt, 0);
        drive(8'h22); idle(1);
        check("tp_rst_no_alu", alu_en, 0);
        idle(2);

        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind < 15) begin
                int c, bad_pos;
                c = $urandom_range(0, 3);
                bad_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lens[c] - 1) : -1;
                for (int k = 0; k < lens[c]; k++) begin
                    logic [7:0] b;
                    b = (k == 0) ? cmds[c] : 8'($urandom);
                    if (k == bad_pos) begin
                        int which;
                        which = $urandom_range(0, 2);
                        drive(b, which != 1, which != 0);
                        break;
                    end
                    drive(b);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
            end else if (kind < 18) begin
                drive(rand_unknown());
            end else if (kind == 18) begin
                pulse_reset();
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
